// File: rtl/queen_pkg.sv
// queen_pkg: shared constants and state encoding for the 8-queens sequencer.
package queen_pkg;
   localparam int BOARD_SIZE = 8;
   localparam int DEPTH_W = 4;
   localparam logic [DEPTH_W-1:0] FULL_DEPTH = DEPTH_W'(BOARD_SIZE);
   typedef enum logic [3:0] {
      IDLE, INIT, PUSH, LOADC, CHECK, PLACE, NEWROW, NEXTCOL, BTPOP, ADV, ADVPOP, EMIT, DONE
   } state_t;
endpackage

// File: rtl/queen_controller.sv
// queen_controller: sequences the backtracking datapath to the first 8-queens solution and streams it out.
module queen_controller
   import queen_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic cout,
   input  logic down_counter_zero,
   input  logic row_zero,
   input  logic last_column,
   input  logic safe,
   input  logic stack_ready,
   input  logic underflow,
   output logic enable_output,
   output logic register_load,
   output logic count,
   output logic load_counter,
   output logic push,
   output logic pop,
   output logic increament_row,
   output logic increament_column,
   output logic load_updated_position,
   output logic reset_column,
   output logic ready,
   output logic done,
   output logic no_solution,
   output logic out_valid
);
   state_t state, state_n;
   logic [DEPTH_W-1:0] depth, depth_n;
   logic no_solution_n;

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state       <= IDLE;
         depth       <= '0;
         no_solution <= 1'b0;
      end else begin
         state       <= state_n;
         depth       <= depth_n;
         no_solution <= no_solution_n;
      end

   always_comb begin
      state_n       = state;
      depth_n       = depth;
      no_solution_n = no_solution;
      case (state)
         IDLE: if (start) begin
            state_n       = INIT;
            no_solution_n = 1'b0;
         end
         INIT: begin
            depth_n = '0;
            state_n = PUSH;
         end
         PUSH: if (stack_ready) begin
            depth_n = depth + 4'd1;
            state_n = LOADC;
         end
         LOADC:   state_n = row_zero ? PLACE : CHECK;
         CHECK:   state_n = !safe ? NEXTCOL : down_counter_zero ? PLACE : CHECK;
         PLACE:   state_n = (depth == FULL_DEPTH) ? EMIT : NEWROW;
         NEWROW:  state_n = PUSH;
         NEXTCOL: state_n = last_column ? BTPOP : ADV;
         // popping the last queen off row 0 means every column there is exhausted
         BTPOP: if (underflow) begin
            no_solution_n = 1'b1;
            state_n       = DONE;
         end else if (stack_ready) begin
            depth_n       = depth - 4'd1;
            no_solution_n = (depth == 4'd1) ? 1'b1 : no_solution;
            state_n       = (depth == 4'd1) ? DONE : NEXTCOL;
         end
         ADV: begin
            no_solution_n = cout ? 1'b1 : no_solution;
            state_n       = cout ? DONE : ADVPOP;
         end
         ADVPOP: if (stack_ready) begin
            depth_n = depth - 4'd1;
            state_n = PUSH;
         end
         EMIT: if (stack_ready) begin
            depth_n = depth - 4'd1;
            state_n = (depth == 4'd1) ? DONE : EMIT;
         end
         DONE:    state_n = start ? DONE : IDLE;
         default: state_n = IDLE;
      endcase
   end

   assign ready                 = state == IDLE;
   assign done                  = state == DONE;
   assign enable_output         = state == EMIT;
   assign register_load         = state == PLACE;
   assign load_counter          = state == LOADC && !row_zero;
   assign count                 = state == CHECK && safe && !down_counter_zero;
   assign push                  = state == PUSH;
   assign pop                   = state == ADVPOP || state == EMIT || (state == BTPOP && !underflow);
   assign increament_row        = state == NEWROW;
   assign increament_column     = state == ADV;
   assign load_updated_position = state == INIT || state == NEWROW || state == ADV;
   assign reset_column          = state == INIT || state == NEWROW;
   assign out_valid             = state == EMIT && stack_ready;
endmodule

// File: tb/tb_queen_controller.sv
// tb_queen_controller: directed checks of the queens sequencer against a behavioral stack/board model.
module tb_queen_controller;
   logic clk = 1'b0, reset = 1'b0, start = 1'b0;
   logic cout, down_counter_zero, row_zero, last_column, safe, stack_ready, underflow;
   logic enable_output, register_load, count, load_counter, push, pop;
   logic increament_row, increament_column, load_updated_position, reset_column;
   logic ready, done, no_solution, out_valid;
   int tests = 0, failed = 0;
   int dly = 1;
   bit force_unsafe = 1'b0, force_uf = 1'b0;
   logic [2:0] srow [8];
   logic [2:0] scol [8];
   logic [3:0] sp;
   logic [2:0] prow, pcol, cnt, ti, trow, tcol, dc, dr;
   int h;
   logic [7:0] out_bus;
   logic [7:0] emitted [$];
   logic [5:0] pushes [$];
   int push_cyc = 0, push_ops = 0, pop_cyc = 0, pop_ops = 0, both = 0;
   localparam logic [7:0] SOL [8] = '{8'h08, 8'h02, 8'h40, 8'h04, 8'h20, 8'h80, 8'h10, 8'h01};

   wire [13:0] outs = {ready, done, no_solution, out_valid, enable_output, register_load, count,
                       load_counter, push, pop, increament_row, increament_column,
                       load_updated_position, reset_column};

   always #5 clk = ~clk;

   queen_controller dut (
      .clk(clk), .reset(reset), .start(start), .cout(cout),
      .down_counter_zero(down_counter_zero), .row_zero(row_zero), .last_column(last_column),
      .safe(safe), .stack_ready(stack_ready), .underflow(underflow),
      .enable_output(enable_output), .register_load(register_load), .count(count),
      .load_counter(load_counter), .push(push), .pop(pop), .increament_row(increament_row),
      .increament_column(increament_column), .load_updated_position(load_updated_position),
      .reset_column(reset_column), .ready(ready), .done(done), .no_solution(no_solution),
      .out_valid(out_valid)
   );

   // stack index equals row; cnt selects the earlier queen under test
   always_comb begin
      ti                = 3'(sp - 4'd1);
      trow              = (sp != 4'd0) ? srow[ti] : 3'd0;
      tcol              = (sp != 4'd0) ? scol[ti] : 3'd0;
      dc                = (tcol > scol[cnt]) ? tcol - scol[cnt] : scol[cnt] - tcol;
      dr                = trow - srow[cnt];
      safe              = !force_unsafe && scol[cnt] != tcol && dc != dr;
      row_zero          = sp != 4'd0 && trow == 3'd0;
      last_column       = tcol == 3'd7;
      down_counter_zero = cnt == 3'd0;
      underflow         = force_uf || sp == 4'd0;
      stack_ready       = (dly == 1) || ((push || pop) && h == dly - 1);
      cout              = load_updated_position && increament_column && tcol == 3'd7;
      out_bus           = 8'd1 << tcol;
   end

   always @(posedge clk or negedge reset)
      if (!reset) begin
         sp   <= 4'd0;
         h    <= 0;
         cnt  <= 3'd0;
         prow <= 3'd0;
         pcol <= 3'd0;
      end else begin
         if (push && stack_ready) begin
            srow[sp[2:0]] <= prow;
            scol[sp[2:0]] <= pcol;
            sp <= sp + 4'd1;
            pushes.push_back({prow, pcol});
         end
         if (pop && stack_ready) sp <= sp - 4'd1;
         h <= ((push || pop) && !stack_ready) ? h + 1 : 0;
         if (load_updated_position) begin
            prow <= (sp == 4'd0) ? 3'd0 : trow + 3'(increament_row);
            pcol <= reset_column ? 3'd0 : tcol + 3'(increament_column);
         end
         if (load_counter) cnt <= trow - 3'd1;
         else if (count) cnt <= cnt - 3'd1;
      end

   always @(posedge clk) begin
      if (out_valid) emitted.push_back(out_bus);
      push_cyc <= push_cyc + int'(push);
      pop_cyc  <= pop_cyc + int'(pop);
      push_ops <= push_ops + int'(push && stack_ready);
      pop_ops  <= pop_ops + int'(pop && stack_ready);
      both     <= both + int'(push && pop);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_for(input string tag, input bit on_done, input int budget);
      int n;
      n = 0;
      while (!(on_done ? done : count) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(tag, 32'(on_done ? done : count), 32'd1);
   endtask

   task automatic begin_run(input string tag);
      start = 1'b1;
      @(negedge clk);
      check({tag, "_init"}, 32'(outs), 32'h0003);
      start = 1'b0;
      @(negedge clk);
      check({tag, "_push"}, 32'(outs), 32'h0020);
   endtask

   task automatic check_solution(input string tag, input int e0);
      check({tag, "_rows"}, 32'(emitted.size() - e0), 32'd8);
      for (int i = 0; i < 8; i++)
         if (emitted.size() > e0 + i)
            check($sformatf("%s_row%0d", tag, 7 - i), 32'(emitted[e0 + i]), 32'(SOL[i]));
   endtask

   initial begin
      int e0, pc0, po0, qc0, qo0, p0;
      #1;
      check("reset_outs", 32'(outs), 32'h2000);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("idle_outs", 32'(outs), 32'h2000);

      begin_run("r0");
      wait_for("r0_reach_check", 1'b0, 2000);
      reset = 1'b0;
      #1;
      check("async_abort", 32'(outs), 32'h2000);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      e0 = emitted.size();
      begin_run("r1");
      wait_for("r1_done", 1'b1, 40000);
      check("r1_done_outs", 32'(outs), 32'h1000);
      check_solution("r1", e0);
      @(negedge clk);
      check("r1_idle", 32'(outs), 32'h2000);

      dly = 3;
      e0  = emitted.size();
      pc0 = push_cyc;
      po0 = push_ops;
      qc0 = pop_cyc;
      qo0 = pop_ops;
      begin_run("r2");
      wait_for("r2_reach_check", 1'b0, 4000);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_for("r2_done", 1'b1, 60000);
      check_solution("r2", e0);
      check("r2_push_hold", 32'(push_cyc - pc0), 32'(3 * (push_ops - po0)));
      check("r2_pop_hold", 32'(pop_cyc - qc0), 32'(3 * (pop_ops - qo0)));
      start = 1'b1;
      repeat (4) @(negedge clk);
      check("done_held", 32'(outs), 32'h1000);
      start = 1'b0;
      @(negedge clk);
      check("r2_idle", 32'(outs), 32'h2000);
      dly = 1;

      force_unsafe = 1'b1;
      p0 = pushes.size();
      begin_run("r3");
      wait_for("r3_done", 1'b1, 5000);
      check("r3_outs", 32'(outs), 32'h1800);
      check("r3_push_count", 32'(pushes.size() - p0), 32'd72);
      if (pushes.size() > p0 + 9) begin
         check("r3_bt_popped", 32'(pushes[p0 + 8]), 32'h0F);
         check("r3_bt_repush", 32'(pushes[p0 + 9]), 32'h01);
      end
      check("r3_stack_empty", 32'(sp), 32'd0);
      force_unsafe = 1'b0;
      @(negedge clk);
      check("r3_sticky", 32'(outs), 32'h2800);
      start = 1'b1;
      @(negedge clk);
      check("r3_clear", 32'(outs), 32'h0003);
      start = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      force_unsafe = 1'b1;
      force_uf     = 1'b1;
      p0 = pushes.size();
      begin_run("r4");
      wait_for("r4_done", 1'b1, 2000);
      check("r4_outs", 32'(outs), 32'h1800);
      check("r4_push_count", 32'(pushes.size() - p0), 32'd9);
      force_unsafe = 1'b0;
      force_uf     = 1'b0;
      @(negedge clk);
      check("r4_sticky", 32'(outs), 32'h2800);
      start = 1'b1;
      @(negedge clk);
      check("r4_clear", 32'(outs), 32'h0003);
      start = 1'b0;
      check("push_pop_exclusive", 32'(both), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
